// File: rtl/esm_issue_scheduler.sv
// esm_issue_scheduler: dependency-tracking issue buffer with registered issue port.
// Optional macro ESM_SCHED_AGE_EN selects oldest-first issue; default is round-robin.
module esm_issue_scheduler #(
    parameter int IW = 32,
    parameter int BS = 16,
    localparam int IB = $clog2(BS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [BS-1:0] in_dep,
    output logic [IB-1:0] alloc_index,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [IB-1:0] issue_index,
    output logic [IW-1:0] issue_instr,
    input  logic          complete_valid,
    input  logic [IB-1:0] complete_index,
    output logic [IB:0]   occupancy,
    output logic          full,
    output logic          empty
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ISSUED = 2'd2
    } ent_st_t;

    ent_st_t       state_q [BS];
    logic [BS-1:0] dep_q   [BS];
    logic [IW-1:0] instr_q [BS];

    logic [BS-1:0] free_vec;
    logic [BS-1:0] ready_vec;
    logic [BS-1:0] cand;
    logic [IB:0]   busy_cnt;
    logic [IB-1:0] alloc_idx;
    logic [BS-1:0] own_oh;
    logic [BS-1:0] cmp_oh;
    logic [BS-1:0] dep_new;
    logic          alloc_go;
    logic          cmp_ok;
    logic          hand;
    logic          sel_found;
    logic [IB-1:0] sel_idx;

    // Per-entry status vectors, occupancy count and lowest-free allocation slot.
    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        busy_cnt  = '0;
        alloc_idx = '0;
        for (int i = 0; i < BS; i++) begin
            free_vec[i]  = (state_q[i] == ST_FREE);
            ready_vec[i] = (state_q[i] == ST_WAIT) && (dep_q[i] == '0);
            if (state_q[i] != ST_FREE) begin
                busy_cnt = busy_cnt + (IB+1)'(1);
            end
        end
        for (int i = BS - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_idx = IB'(i);
            end
        end
    end

    assign full        = (busy_cnt == (IB+1)'(BS));
    assign empty       = (busy_cnt == '0);
    assign occupancy   = busy_cnt;
    assign in_ready    = !full;
    assign alloc_index = alloc_idx;

    assign alloc_go = in_valid && in_ready;
    assign cmp_ok   = complete_valid && (state_q[complete_index] == ST_ISSUED);
    assign hand     = issue_valid && issue_ready;

    // Dependency row for the newly allocated entry, pruned of stale producers.
    always_comb begin
        own_oh = '0;
        cmp_oh = '0;
        own_oh[alloc_idx] = 1'b1;
        if (cmp_ok) begin
            cmp_oh[complete_index] = 1'b1;
        end
        dep_new = in_dep & ~free_vec & ~own_oh & ~cmp_oh;
    end

    // Ready entries, minus the one currently presented on the issue port.
    always_comb begin
        cand = ready_vec;
        if (issue_valid) begin
            cand[issue_index] = 1'b0;
        end
    end

`ifdef ESM_SCHED_AGE_EN
    // age_q[j][i] set means entry j was allocated before entry i.
    logic [BS-1:0] age_q [BS];

    // Record relative age of each new entry against all live entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BS; i++) begin
                age_q[i] <= '0;
            end
        end else if (alloc_go) begin
            age_q[alloc_idx] <= '0;
            for (int j = 0; j < BS; j++) begin
                age_q[j][alloc_idx] <= !free_vec[j];
            end
        end
    end

    // Oldest-first pick: the candidate with no older candidate.
    always_comb begin
        logic older;
        sel_found = 1'b0;
        sel_idx   = '0;
        older     = 1'b0;
        for (int i = 0; i < BS; i++) begin
            older = 1'b0;
            for (int j = 0; j < BS; j++) begin
                if (cand[j] && age_q[j][i]) begin
                    older = 1'b1;
                end
            end
            if (!sel_found && cand[i] && !older) begin
                sel_found = 1'b1;
                sel_idx   = IB'(i);
            end
        end
    end
`else
    logic [IB-1:0] rr_ptr;

    // Round-robin pick starting just after the last selected entry.
    always_comb begin
        logic [IB-1:0] idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= BS; k++) begin
            idx = rr_ptr + IB'(k);
            if (!sel_found && cand[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    // Remember the last entry loaded onto the issue port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= IB'(BS - 1);
        end else if ((!issue_valid || issue_ready) && sel_found) begin
            rr_ptr <= sel_idx;
        end
    end
`endif

    // Entry lifecycle and dependency matrix updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BS; i++) begin
                state_q[i] <= ST_FREE;
                dep_q[i]   <= '0;
            end
        end else begin
            if (cmp_ok) begin
                for (int i = 0; i < BS; i++) begin
                    dep_q[i][complete_index] <= 1'b0;
                end
                state_q[complete_index] <= ST_FREE;
            end
            if (hand) begin
                state_q[issue_index] <= ST_ISSUED;
            end
            if (alloc_go) begin
                state_q[alloc_idx] <= ST_WAIT;
                dep_q[alloc_idx]   <= dep_new;
            end
        end
    end

    // Instruction storage needs no reset; it is only read for WAIT entries.
    always_ff @(posedge clk) begin
        if (alloc_go) begin
            instr_q[alloc_idx] <= in_instr;
        end
    end

    // Registered issue port: load a new pick whenever the slot is empty or drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid <= 1'b0;
            issue_index <= '0;
            issue_instr <= '0;
        end else if (!issue_valid || issue_ready) begin
            issue_valid <= sel_found;
            if (sel_found) begin
                issue_index <= sel_idx;
                issue_instr <= instr_q[sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// tb_esm_issue_scheduler: directed bench for esm_issue_scheduler.
// Expected ordering follows ESM_SCHED_AGE_EN when that macro is defined.
module tb_esm_issue_scheduler;

    localparam int IW = 32;
    localparam int BS = 16;
    localparam int IB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic [BS-1:0] in_dep;
    logic [IB-1:0] alloc_index;
    logic          issue_valid;
    logic          issue_ready;
    logic [IB-1:0] issue_index;
    logic [IW-1:0] issue_instr;
    logic          complete_valid;
    logic [IB-1:0] complete_index;
    logic [IB:0]   occupancy;
    logic          full;
    logic          empty;

    int n_tests = 0;
    int n_fail  = 0;

    esm_issue_scheduler #(.IW(IW), .BS(BS)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_dep        (in_dep),
        .alloc_index   (alloc_index),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_index   (issue_index),
        .issue_instr   (issue_instr),
        .complete_valid(complete_valid),
        .complete_index(complete_index),
        .occupancy     (occupancy),
        .full          (full),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid       = 1'b0;
        complete_valid = 1'b0;
    endtask

    task automatic offer(input logic [IW-1:0] w, input logic [BS-1:0] d);
        in_valid = 1'b1;
        in_instr = w;
        in_dep   = d;
    endtask

    task automatic complete(input int idx);
        in_valid       = 1'b0;
        complete_valid = 1'b1;
        complete_index = IB'(idx);
        step();
        complete_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        in_instr       = '0;
        in_dep         = '0;
        issue_ready    = 1'b0;
        complete_valid = 1'b0;
        complete_index = '0;
        #12;
        chk("rst_occ", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alloc", alloc_index, 0);
        chk("rst_iv", issue_valid, 0);
        chk("rst_iidx", issue_index, 0);
        chk("rst_iinstr", issue_instr, 0);
        rst = 1'b0;
        step();

        // back-to-back allocation and issue
        issue_ready = 1'b1;
        chk("b2b_alloc0", alloc_index, 0);
        offer(32'hA000_0000, '0);
        step();
        chk("b2b_lat_iv", issue_valid, 0);
        chk("b2b_alloc1", alloc_index, 1);
        chk("b2b_occ1", occupancy, 1);
        offer(32'hA000_0001, '0);
        step();
        chk("b2b_iv0", issue_valid, 1);
        chk("b2b_idx0", issue_index, 0);
        chk("b2b_ins0", issue_instr, 32'hA000_0000);
        chk("b2b_alloc2", alloc_index, 2);
        offer(32'hA000_0002, '0);
        step();
        chk("b2b_idx1", issue_index, 1);
        chk("b2b_ins1", issue_instr, 32'hA000_0001);
        idle();
        step();
        chk("b2b_idx2", issue_index, 2);
        chk("b2b_ins2", issue_instr, 32'hA000_0002);
        step();
        chk("b2b_drain_iv", issue_valid, 0);
        chk("b2b_occ3", occupancy, 3);
        complete(0);
        complete(1);
        complete(2);
        chk("b2b_occ0", occupancy, 0);
        chk("b2b_empty", empty, 1);

        // consumer waits on producer completion
        chk("dep_alloc0", alloc_index, 0);
        offer(32'hB000_0000, '0);
        step();
        offer(32'hB000_0001, 16'h0001);
        step();
        chk("dep_iv0", issue_valid, 1);
        chk("dep_idx0", issue_index, 0);
        idle();
        step();
        chk("dep_block_a", issue_valid, 0);
        step();
        step();
        chk("dep_block_b", issue_valid, 0);
        complete(0);
        chk("dep_cmp_edge", issue_valid, 0);
        step();
        chk("dep_iv1", issue_valid, 1);
        chk("dep_idx1", issue_index, 1);
        chk("dep_ins1", issue_instr, 32'hB000_0001);
        step();
        chk("dep_drain", issue_valid, 0);
        complete(1);

        // dependency on a producer completing in the same cycle
        offer(32'hC000_0000, '0);
        step();
        idle();
        step();
        chk("same_idx0", issue_index, 0);
        step();
        chk("same_iv_off", issue_valid, 0);
        chk("same_alloc1", alloc_index, 1);
        offer(32'hC000_0001, 16'h0021);
        complete_valid = 1'b1;
        complete_index = 4'd0;
        step();
        idle();
        chk("same_occ", occupancy, 1);
        chk("same_realloc0", alloc_index, 0);
        step();
        chk("same_iv1", issue_valid, 1);
        chk("same_idx1", issue_index, 1);
        chk("same_ins1", issue_instr, 32'hC000_0001);
        step();
        chk("same_drain", issue_valid, 0);
        complete(1);

        // backpressure holds the issue port
        issue_ready = 1'b0;
        offer(32'hD000_0000, '0);
        step();
        offer(32'hD000_0001, '0);
        step();
        idle();
        chk("hold_iv", issue_valid, 1);
        chk("hold_idx", issue_index, 0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("hold_iv_c", issue_valid, 1);
            chk("hold_idx_c", issue_index, 0);
            chk("hold_ins_c", issue_instr, 32'hD000_0000);
        end
        issue_ready = 1'b1;
        step();
        chk("hold_rel_idx", issue_index, 1);
        chk("hold_rel_ins", issue_instr, 32'hD000_0001);
        step();
        chk("hold_drain", issue_valid, 0);
        complete(0);
        complete(1);

        // entries 2 and 5 become ready together after entry 3 issued last
        offer(32'hE000_0000, 16'h0000);
        step();
        offer(32'hE000_0001, 16'h0000);
        step();
        offer(32'hE000_0002, 16'h0001);
        step();
        offer(32'hE000_0003, 16'h0000);
        step();
        offer(32'hE000_0004, 16'h0008);
        step();
        offer(32'hE000_0005, 16'h0001);
        step();
        idle();
        step();
        chk("sel_iv_idle", issue_valid, 0);
        chk("sel_occ6", occupancy, 6);
        complete(0);
        chk("sel_cmp_edge", issue_valid, 0);
        step();
        chk("sel_first_iv", issue_valid, 1);
`ifdef ESM_SCHED_AGE_EN
        chk("sel_first", issue_index, 2);
        step();
        chk("sel_second", issue_index, 5);
`else
        chk("sel_first", issue_index, 5);
        step();
        chk("sel_second", issue_index, 2);
`endif
        step();
        chk("sel_drain", issue_valid, 0);

        // reset in mid-operation discards everything
        issue_ready = 1'b0;
        chk("mid_alloc0", alloc_index, 0);
        offer(32'hF0F0_1234, '0);
        step();
        idle();
        step();
        chk("mid_pre_iv", issue_valid, 1);
        chk("mid_pre_ins", issue_instr, 32'hF0F0_1234);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_occ", occupancy, 0);
        chk("mid_iv", issue_valid, 0);
        chk("mid_ins", issue_instr, 0);
        chk("mid_empty", empty, 1);
        chk("mid_alloc", alloc_index, 0);
        #3;
        rst = 1'b0;
        step();

        // fill to full, ignore extra offers, free one slot
        issue_ready = 1'b1;
        for (int i = 0; i < BS; i++) begin
            chk("fill_alloc", alloc_index, i);
            offer(32'h9000_0000 + i, '0);
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_occ", occupancy, 16);
        offer(32'hDEAD_BEEF, '0);
        for (int c = 0; c < 20; c++) begin
            step();
        end
        chk("full_occ_hold", occupancy, 16);
        chk("full_still", full, 1);
        chk("full_drained", issue_valid, 0);
        complete(7);
        chk("free_full", full, 0);
        chk("free_in_ready", in_ready, 1);
        chk("free_alloc", alloc_index, 7);
        chk("free_occ", occupancy, 15);
        offer(32'h7777_0007, '0);
        complete_valid = 1'b1;
        complete_index = 4'd3;
        step();
        idle();
        chk("net0_occ", occupancy, 15);
        chk("net0_alloc", alloc_index, 3);
        step();
        chk("net0_iv", issue_valid, 1);
        chk("net0_idx", issue_index, 7);
        chk("net0_ins", issue_instr, 32'h7777_0007);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/esm_issue_scheduler.md
ESM_ISSUE_SCHEDULER -- requirements
Module: esm_issue_scheduler

Interface
REQ-001 Parameter IW, default 32: instruction word width.
REQ-002 Parameter BS, default 16, power of two >= 2: buffer entries; IB = log2(BS).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  new instruction offered.
REQ-006 in_ready  output  1  scheduler can accept; equals !full.
REQ-007 in_instr  input  IW  instruction word to buffer.
REQ-008 in_dep  input  BS  producer-entry dependency vector for the offered instruction (bit j = depends on entry j).
REQ-009 alloc_index  output  IB  entry the offered instruction will occupy; valid while in_ready=1.
REQ-010 issue_valid  output  1  registered issue request.
REQ-011 issue_ready  input  1  downstream accepts issue.
REQ-012 issue_index  output  IB  entry being issued.
REQ-013 issue_instr  output  IW  instruction word of issue_index.
REQ-014 complete_valid  input  1  an issued entry finished execution.
REQ-015 complete_index  input  IB  entry that finished.
REQ-016 occupancy  output  IB+1  count of non-FREE entries.
REQ-017 full, empty  output  1 each  occupancy==BS, occupancy==0.

Function
REQ-018 Each entry SHALL hold state FREE, WAIT or ISSUED, an IW-bit word and a BS-bit dependency row (row = consumer, column = producer).
REQ-019 alloc_index SHALL be the lowest-indexed FREE entry, derived from registered state only.
REQ-020 On in_valid && in_ready the entry at alloc_index SHALL become WAIT, store in_instr, and store in_dep masked by: own bit cleared, bits of FREE entries cleared, bit complete_index cleared when complete_valid in the same cycle.
REQ-021 An entry is ready when state==WAIT and dependency row==0.
REQ-022 When issue_valid==0 or (issue_valid && issue_ready), the scheduler SHALL register the next selected ready entry into issue_index/issue_instr and assert issue_valid; if none ready, issue_valid SHALL deassert.
REQ-023 While issue_valid && !issue_ready, issue_valid, issue_index, issue_instr SHALL hold stable.
REQ-024 On issue handshake the entry SHALL become ISSUED and SHALL NOT be selected again; the entry being handed over SHALL be excluded from the same-cycle selection.
REQ-025 Minimum latency: instruction with zero effective deps accepted at edge N SHALL present issue_valid after edge N+1.
REQ-026 On complete_valid for an ISSUED entry: column complete_index SHALL clear in every row, and the entry SHALL become FREE, at the same edge.
REQ-027 complete_valid for a non-ISSUED entry SHALL be ignored (no state change).
REQ-028 A slot freed by completion SHALL be allocatable no earlier than the following cycle.
REQ-029 When full, in_valid SHALL be ignored; simultaneous allocate and complete SHALL update occupancy by net +0.
REQ-030 Default selection SHALL be round-robin: search starts at entry after last issued index, wrapping modulo BS.

Reset
REQ-031 On rst: all entries FREE, rows zero, issue_valid=0, issue_index=0, issue_instr=0, round-robin pointer=BS-1, occupancy=0, empty=1, full=0, in_ready=1, alloc_index=0.
REQ-032 Reset mid-operation SHALL discard all buffered and pending-issue instructions; no completion is expected afterwards.

Configuration
REQ-033 Macro ESM_SCHED_AGE_EN: when defined, selection SHALL be oldest-first via a BS x BS age matrix set on allocation (new entry younger than all valid entries); when undefined, REQ-030 round-robin applies and no age storage exists.

Verification
REQ-034 Reset, then offer 3 instrs with in_dep=0 back-to-back, issue_ready=1 -> alloc_index 0,1,2; issue_index 0,1,2 on consecutive cycles starting edge after first accept.
REQ-035 Entry 0 issued, entry 1 in_dep=16'h0001 -> entry 1 not issued until complete_valid/complete_index=0; issue_valid for entry 1 after following edge.
REQ-036 Fill 16 entries, no completes -> full=1, in_ready=0, occupancy=16; extra in_valid ignored; one complete -> full=0 next cycle, alloc_index=freed entry.
REQ-037 issue_ready held 0 for 5 cycles with ready entries -> issue_index/issue_instr unchanged for all 5 cycles.
REQ-038 in_dep bit j where entry j completes in same cycle -> stored row bit j=0, instruction issues without further completion.
REQ-039 Entries 5 and 2 ready, last issued 3: no ESM_SCHED_AGE_EN -> 5 first; with ESM_SCHED_AGE_EN and 5 allocated before 2 -> 5 first, and 2 first if 2 allocated earlier.
